// File: rtl/bj_pkg.sv
// Types and helpers shared by the blackjack datapath: card field widths, the
// card payload, the shoe state encoding and the rank-to-value mapping.
package bj_pkg;

  localparam int unsigned CARD_W    = 5;
  localparam int unsigned RANK_W    = 4;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned DECK_SIZE = 52;

  typedef enum logic [2:0] {
    SHOE_IDLE,
    SHOE_PROBE,
    SHOE_DELIVER,
    SHOE_EMPTY,
    SHOE_SHUFFLE
  } shoe_state_e;

  typedef struct packed {
    logic [CARD_W-1:0] value;
    logic [RANK_W-1:0] rank;
    logic [IDX_W-1:0]  index;
  } card_t;

  // Ace counts 1; the face cards (rank 10..12) and the ten all count 10.
  function automatic logic [CARD_W-1:0] rank_to_value(input logic [RANK_W-1:0] rank);
    if (rank < RANK_W'(9)) begin
      return CARD_W'(rank) + CARD_W'(1);
    end
    return CARD_W'(10);
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// 6-bit Fibonacci LFSR, polynomial x^6+x^5+1 (period 63), advancing every clock.
module card_lfsr
  import bj_pkg::*;
#(
  parameter logic [IDX_W-1:0] SEED = 6'h2D
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic [IDX_W-1:0] lfsr_value
);

  logic [IDX_W-1:0] lfsr_q;
  logic [IDX_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_value = lfsr_q;

endmodule

// File: rtl/card_shoe.sv
// Single-deck card shoe: deals without replacement from a 52-slot dealt mask,
// starting the slot search at an LFSR-chosen position.
module card_shoe
  import bj_pkg::*;
#(
  parameter logic [IDX_W-1:0] LFSR_SEED = 6'h2D
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              draw_req,
  input  logic              shuffle,
  output logic              card_valid,
  output logic [CARD_W-1:0] card_value,
  output logic [RANK_W-1:0] card_rank,
  output logic [IDX_W-1:0]  card_index,
  output logic              busy,
  output logic              deck_empty,
  output logic [IDX_W-1:0]  cards_left,
  output logic              draw_err
);

  shoe_state_e          state_q, state_d;
  logic [DECK_SIZE-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     left_q, left_d;
  card_t                card_q, card_d;
  logic                 card_valid_q, card_valid_d;
  logic                 draw_err_q, draw_err_d;
  logic                 busy_q, busy_d;
  logic [IDX_W-1:0]     lfsr_value;

  card_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clock      (clock),
    .reset_n    (reset_n),
    .lfsr_value (lfsr_value)
  );

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    ptr_d        = ptr_q;
    left_d       = left_q;
    card_d       = card_q;
    card_valid_d = 1'b0;
    draw_err_d   = 1'b0;

    unique case (state_q)
      SHOE_IDLE: begin
        // A shuffle wins over a simultaneous draw, which is dropped.
        if (shuffle) begin
          state_d = SHOE_SHUFFLE;
        end else if (draw_req) begin
          ptr_d   = (lfsr_value >= IDX_W'(DECK_SIZE)) ? lfsr_value - IDX_W'(DECK_SIZE)
                                                      : lfsr_value;
          state_d = SHOE_PROBE;
        end
      end
      SHOE_PROBE: begin
        if (!mask_q[ptr_q]) begin
          mask_d[ptr_q] = 1'b1;
          left_d        = left_q - IDX_W'(1);
          card_d.index  = ptr_q;
          card_d.rank   = RANK_W'(ptr_q >> 2);
          card_d.value  = rank_to_value(RANK_W'(ptr_q >> 2));
          state_d       = SHOE_DELIVER;
        end else begin
          ptr_d = (ptr_q == IDX_W'(DECK_SIZE - 1)) ? '0 : ptr_q + IDX_W'(1);
        end
      end
      SHOE_DELIVER: begin
        card_valid_d = 1'b1;
        state_d      = (left_q == '0) ? SHOE_EMPTY : SHOE_IDLE;
      end
      SHOE_EMPTY: begin
        if (shuffle) begin
          state_d = SHOE_SHUFFLE;
        end else if (draw_req) begin
          draw_err_d = 1'b1;
        end
      end
      SHOE_SHUFFLE: begin
        mask_d  = '0;
        left_d  = IDX_W'(DECK_SIZE);
        state_d = SHOE_IDLE;
      end
      default: begin
        state_d = SHOE_IDLE;
      end
    endcase

    busy_d = (state_d == SHOE_PROBE) || (state_d == SHOE_DELIVER) ||
             (state_d == SHOE_SHUFFLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SHOE_IDLE;
      mask_q       <= '0;
      ptr_q        <= '0;
      left_q       <= IDX_W'(DECK_SIZE);
      card_q       <= '0;
      card_valid_q <= 1'b0;
      draw_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      ptr_q        <= ptr_d;
      left_q       <= left_d;
      card_q       <= card_d;
      card_valid_q <= card_valid_d;
      draw_err_q   <= draw_err_d;
      busy_q       <= busy_d;
    end
  end

  assign card_valid = card_valid_q;
  assign card_value = card_q.value;
  assign card_rank  = card_q.rank;
  assign card_index = card_q.index;
  assign busy       = busy_q;
  assign cards_left = left_q;
  assign draw_err   = draw_err_q;
  // Also high during DELIVER of the last card, since the count drops on the hit.
  assign deck_empty = (left_q == '0);

endmodule

// File: tb/tb_card_shoe.sv
// Scoreboard bench for card_shoe: a deck/LFSR model predicts each dealt slot
// and its latency; a negedge monitor checks every card_valid against it.
module tb_card_shoe;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       draw_req = 1'b0;
  logic       shuffle = 1'b0;
  logic       card_valid;
  logic [4:0] card_value;
  logic [3:0] card_rank;
  logic [5:0] card_index;
  logic       busy;
  logic       deck_empty;
  logic [5:0] cards_left;
  logic       draw_err;

  card_shoe #(.LFSR_SEED(6'h2D)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .draw_req   (draw_req),
    .shuffle    (shuffle),
    .card_valid (card_valid),
    .card_value (card_value),
    .card_rank  (card_rank),
    .card_index (card_index),
    .busy       (busy),
    .deck_empty (deck_empty),
    .cards_left (cards_left),
    .draw_err   (draw_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int idx;
    int issue;
    int probes;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  int          n_valid = 0;
  int          last_idx = -1;
  int          last_lat = -1;
  int          val_cnt[11];
  logic [51:0] seen = '0;
  bit          err_ok = 1'b0;
  logic [5:0]  m_lfsr;
  logic [51:0] m_mask = '0;
  int          m_left = 52;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Reference LFSR, x^6+x^5+1 from the seed.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 6'h2D;
    else          m_lfsr <= {m_lfsr[4:0], m_lfsr[5] ^ m_lfsr[4]};
  end

  always @(negedge clock) begin
    if (reset_n) begin
      if (card_valid) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("card_index", int'(card_index), mon_e.idx);
          check("card_rank", int'(card_rank), mon_e.idx / 4);
          check("card_value", int'(card_value), (mon_e.idx / 4 < 9) ? mon_e.idx / 4 + 1 : 10);
          check("latency", cyc - mon_e.issue, 2 + mon_e.probes);
          last_lat = cyc - mon_e.issue;
        end
        last_idx = int'(card_index);
        if (card_value <= 5'd10) val_cnt[card_value]++;
        if (card_index < 6'd52) seen[card_index] = 1'b1;
      end
      if (draw_err && !err_ok) check("spurious_draw_err", 1, 0);
    end
  end

  function automatic int ptr_of(input logic [5:0] l);
    return (l >= 6'd52) ? int'(l) - 52 : int'(l);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Predict the dealt slot from the model deck, queue it, pulse draw_req.
  task automatic issue_draw();
    exp_t e;
    int p = ptr_of(m_lfsr);
    int k = 1;
    while (m_mask[p] && k <= 52) begin
      p = (p == 51) ? 0 : p + 1;
      k++;
    end
    m_mask[p] = 1'b1;
    m_left--;
    e.idx = p;
    e.issue = cyc;
    e.probes = k;
    exp_q.push_back(e);
    draw_req = 1'b1;
    step();
    draw_req = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 80; i++) begin
      if (exp_q.size() == 0 && !busy) return;
      step();
    end
    check("deal_timeout", 1, 0);
    exp_q.delete();
  endtask

  task automatic wait_ptr(input int target);
    for (int i = 0; i < 70; i++) begin
      if (ptr_of(m_lfsr) == target) return;
      step();
    end
    check("ptr_timeout", 1, 0);
  endtask

  initial begin
    int nv;

    // Reset values
    repeat (3) step();
    check("rst_cards_left", int'(cards_left), 52);
    check("rst_busy", int'(busy), 0);
    check("rst_deck_empty", int'(deck_empty), 0);
    check("rst_card_valid", int'(card_valid), 0);
    check("rst_draw_err", int'(draw_err), 0);
    check("rst_card_fields", int'({card_value, card_rank, card_index}), 0);
    reset_n = 1'b1;
    step();

    // Full deck dealt with random gaps
    for (int n = 0; n < 52; n++) begin
      issue_draw();
      wait_done();
      repeat ($urandom_range(0, 3)) step();
    end
    for (int v = 1; v <= 9; v++) check("value_count", val_cnt[v], 4);
    check("value10_count", val_cnt[10], 16);
    check("all_slots_seen", int'(&seen), 1);
    check("empty_cards_left", int'(cards_left), 0);
    check("empty_deck_empty", int'(deck_empty), 1);
    check("empty_busy", int'(busy), 0);

    // Draw on empty deck, then shuffle
    nv = n_valid;
    err_ok = 1'b1;
    draw_req = 1'b1;
    step();
    draw_req = 1'b0;
    check("draw_err_pulse", int'(draw_err), 1);
    step();
    err_ok = 1'b0;
    check("draw_err_clear", int'(draw_err), 0);
    check("err_cards_left", int'(cards_left), 0);
    repeat (3) step();
    check("err_no_card", n_valid - nv, 0);
    shuffle = 1'b1;
    step();
    shuffle = 1'b0;
    check("shuffle_busy", int'(busy), 1);
    step();
    check("shuffle_cards_left", int'(cards_left), 52);
    check("shuffle_deck_empty", int'(deck_empty), 0);
    check("shuffle_idle", int'(busy), 0);
    m_mask = '0;
    m_left = 52;

    // Wrap from slot 51 to 0, with draws ignored while busy
    wait_ptr(51);
    issue_draw();
    wait_done();
    nv = n_valid;
    wait_ptr(51);
    issue_draw();
    for (int i = 0; i < 3; i++) begin
      check("busy_during_ignore", int'(busy), 1);
      draw_req = 1'b1;
      step();
      draw_req = 1'b0;
    end
    wait_done();
    repeat (5) step();
    check("ignore_one_card", n_valid - nv, 1);
    check("wrap_index", last_idx, 0);
    check("ignore_cards_left", int'(cards_left), 50);

    // Simultaneous draw and shuffle in IDLE
    nv = n_valid;
    draw_req = 1'b1;
    shuffle = 1'b1;
    step();
    draw_req = 1'b0;
    shuffle = 1'b0;
    check("both_busy", int'(busy), 1);
    step();
    check("both_cards_left", int'(cards_left), 52);
    repeat (5) step();
    check("both_no_card", n_valid - nv, 0);
    m_mask = '0;
    m_left = 52;

    // Deal slots 0..50 in order, then a 52-probe search for slot 51
    for (int s = 0; s < 51; s++) begin
      wait_ptr(s);
      issue_draw();
      wait_done();
    end
    wait_ptr(0);
    issue_draw();
    wait_done();
    check("last_index", last_idx, 51);
    check("last_latency", last_lat, 54);
    check("last_rank", int'(card_rank), 12);
    check("last_value", int'(card_value), 10);
    check("last_cards_left", int'(cards_left), 0);
    check("last_deck_empty", int'(deck_empty), 1);

    // Reset in the middle of PROBE
    shuffle = 1'b1;
    step();
    shuffle = 1'b0;
    repeat (2) step();
    m_mask = '0;
    m_left = 52;
    issue_draw();
    reset_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(card_valid), 0);
    exp_q.delete();
    m_mask = '0;
    m_left = 52;
    repeat (2) step();
    check("midrst_cards_left", int'(cards_left), 52);
    reset_n = 1'b1;
    nv = n_valid;
    issue_draw();
    wait_done();
    check("post_rst_one_card", n_valid - nv, 1);
    check("post_rst_seed_slot", last_idx, 45);
    check("post_rst_cards_left", int'(cards_left), 51);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
